// File: rtl/distribuitor_rest_pkg.sv
// Shared definitions for the change dispenser and the vending FSM that drives it.
package distribuitor_rest_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      PLATA5,
      PAUZA,
      PLATA1,
      DONE,
      EROARE
   } stare_t;

   localparam int VAL_5 = 5;

   localparam int AMOUNT_W_DEF   = 4;
   localparam int STOC_W_DEF     = 5;
   localparam int STOC5_INIT_DEF = 4;
   localparam int STOC1_INIT_DEF = 8;
   localparam int PULSE_GAP_DEF  = 2;

endpackage

// File: rtl/distribuitor_rest_hopper_stoc.sv
// Coin stock for one hopper: decrements once per ejected coin, reloads to INIT on reset or refill.
module hopper_stoc #(
   parameter int W    = 5,
   parameter int INIT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         dec,
   input  logic         reload,
   output logic [W-1:0] stoc,
   output logic         gol
);

   always_ff @(posedge clk) begin
      if (reset || reload)
         stoc <= W'(INIT);
      else if (dec)
         stoc <= stoc - W'(1);
   end

   assign gol = (stoc == '0);

endmodule

// File: rtl/distribuitor_rest.sv
// Change dispenser: plans 5-leu coins first, checks 1-leu stock, then pulses one coin at a time.
// Request to first coin takes n5+2 cycles; busy requests are dropped while gata=0.
module distribuitor_rest
   import distribuitor_rest_pkg::*;
#(
   parameter int AMOUNT_W   = AMOUNT_W_DEF,
   parameter int STOC_W     = STOC_W_DEF,
   parameter int STOC5_INIT = STOC5_INIT_DEF,
   parameter int STOC1_INIT = STOC1_INIT_DEF,
   parameter int PULSE_GAP  = PULSE_GAP_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cerere_rest,
   input  logic [AMOUNT_W-1:0] suma_rest,
   input  logic                reincarca,
   output logic                gata,
   output logic                moneda_5lei,
   output logic                moneda_1leu,
   output logic                terminat,
   output logic                eroare,
   output logic                gol_1leu
);

   localparam int CW    = (AMOUNT_W > STOC_W) ? AMOUNT_W : STOC_W;
   localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

   stare_t              stare;
   logic [AMOUNT_W-1:0] rest;
   logic [AMOUNT_W-1:0] n5;
   logic [AMOUNT_W-1:0] rest_dec;
   logic [AMOUNT_W-1:0] n5_dec;
   logic [GAP_W-1:0]    gap;
   logic [STOC_W-1:0]   stoc5;
   logic [STOC_W-1:0]   stoc1;
   logic                gol_5lei;
   logic                reload;

   // A request in the same cycle as a refill wins; the refill is dropped.
   assign reload   = (stare == IDLE) && reincarca && !cerere_rest;
   assign rest_dec = rest - AMOUNT_W'(1);
   assign n5_dec   = n5 - AMOUNT_W'(1);

   hopper_stoc #(.W(STOC_W), .INIT(STOC5_INIT)) u_hop5 (
      .clk    (clk),
      .reset  (reset),
      .dec    (stare == PLATA5),
      .reload (reload),
      .stoc   (stoc5),
      .gol    (gol_5lei)
   );

   hopper_stoc #(.W(STOC_W), .INIT(STOC1_INIT)) u_hop1 (
      .clk    (clk),
      .reset  (reset),
      .dec    (stare == PLATA1),
      .reload (reload),
      .stoc   (stoc1),
      .gol    (gol_1leu)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         stare       <= IDLE;
         gata        <= 1'b1;
         moneda_5lei <= 1'b0;
         moneda_1leu <= 1'b0;
         terminat    <= 1'b0;
         eroare      <= 1'b0;
         rest        <= '0;
         n5          <= '0;
         gap         <= '0;
      end else begin
         moneda_5lei <= 1'b0;
         moneda_1leu <= 1'b0;
         terminat    <= 1'b0;
         case (stare)
            IDLE: begin
               if (cerere_rest) begin
                  rest   <= suma_rest;
                  n5     <= '0;
                  eroare <= 1'b0;
                  gata   <= 1'b0;
                  stare  <= CALC;
               end
            end
            CALC: begin
               if (rest >= AMOUNT_W'(VAL_5) && !gol_5lei && CW'(n5) < CW'(stoc5)) begin
                  rest <= rest - AMOUNT_W'(VAL_5);
                  n5   <= n5 + AMOUNT_W'(1);
               end else if (CW'(rest) > CW'(stoc1)) begin
                  stare <= EROARE;
               end else if (n5 != '0) begin
                  stare       <= PLATA5;
                  moneda_5lei <= 1'b1;
               end else if (rest != '0) begin
                  stare       <= PLATA1;
                  moneda_1leu <= 1'b1;
               end else begin
                  stare    <= DONE;
                  terminat <= 1'b1;
               end
            end
            PLATA5: begin
               n5 <= n5_dec;
               if (n5_dec == '0 && rest == '0) begin
                  stare    <= DONE;
                  terminat <= 1'b1;
               end else if (PULSE_GAP == 0) begin
                  if (n5_dec != '0) begin
                     stare       <= PLATA5;
                     moneda_5lei <= 1'b1;
                  end else begin
                     stare       <= PLATA1;
                     moneda_1leu <= 1'b1;
                  end
               end else begin
                  stare <= PAUZA;
                  gap   <= GAP_W'(PULSE_GAP - 1);
               end
            end
            PLATA1: begin
               rest <= rest_dec;
               if (rest_dec == '0) begin
                  stare    <= DONE;
                  terminat <= 1'b1;
               end else if (PULSE_GAP == 0) begin
                  stare       <= PLATA1;
                  moneda_1leu <= 1'b1;
               end else begin
                  stare <= PAUZA;
                  gap   <= GAP_W'(PULSE_GAP - 1);
               end
            end
            PAUZA: begin
               if (gap != '0) begin
                  gap <= gap - GAP_W'(1);
               end else if (n5 != '0) begin
                  stare       <= PLATA5;
                  moneda_5lei <= 1'b1;
               end else begin
                  stare       <= PLATA1;
                  moneda_1leu <= 1'b1;
               end
            end
            DONE: begin
               stare <= IDLE;
               gata  <= 1'b1;
            end
            EROARE: begin
               eroare <= 1'b1;
               stare  <= IDLE;
               gata   <= 1'b1;
            end
            default: begin
               stare <= IDLE;
               gata  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_distribuitor_rest.sv
// Directed bench for the change dispenser; expected coin/terminat/eroare events go to a scoreboard queue.
module tb_distribuitor_rest;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cerere_rest = 1'b0;
   logic [3:0] suma_rest = 4'd0;
   logic       reincarca = 1'b0;
   logic       gata, moneda_5lei, moneda_1leu, terminat, eroare, gol_1leu;

   distribuitor_rest dut (
      .clk         (clk),
      .reset       (reset),
      .cerere_rest (cerere_rest),
      .suma_rest   (suma_rest),
      .reincarca   (reincarca),
      .gata        (gata),
      .moneda_5lei (moneda_5lei),
      .moneda_1leu (moneda_1leu),
      .terminat    (terminat),
      .eroare      (eroare),
      .gol_1leu    (gol_1leu)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 1 = 5-leu coin, 2 = 1-leu coin, 3 = terminat, 4 = eroare rising
   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   function automatic string kname(int k);
      case (k)
         1:       return "coin5";
         2:       return "coin1";
         3:       return "terminat";
         4:       return "eroare";
         default: return "unknown";
      endcase
   endfunction

   task automatic chk(string name, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   task automatic pop(int kind);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_%s: got event at cycle %0d, expected none", kname(kind), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc) begin
            n_bad++;
            $display("FAIL event: got %s@%0d, expected %s@%0d", kname(kind), cyc, kname(e.kind), e.cyc);
         end
      end
   endtask

   task automatic push(int kind, int c);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic at(int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic req(int s);
      cerere_rest = 1'b1;
      suma_rest   = 4'(s);
      @(negedge clk);
      cerere_rest = 1'b0;
   endtask

   task automatic refill();
      reincarca = 1'b1;
      @(negedge clk);
      reincarca = 1'b0;
   endtask

   // Monitor: pops one expectation per observed output event.
   initial begin
      logic er_q;
      er_q = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) chk("coin_overlap", int'(moneda_5lei & moneda_1leu), 0);
         if (moneda_5lei === 1'b1) pop(1);
         if (moneda_1leu === 1'b1) pop(2);
         if (terminat === 1'b1) pop(3);
         if (eroare === 1'b1 && !er_q) pop(4);
         er_q = (eroare === 1'b1);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end, expected finish");
      $fatal(1);
   end

   initial begin
      int t;
      @(negedge clk);
      reset = 1'b1;
      at(2);
      reset = 1'b0;
      chk("rst_gata", int'(gata), 1);
      chk("rst_coin5", int'(moneda_5lei), 0);
      chk("rst_coin1", int'(moneda_1leu), 0);
      chk("rst_terminat", int'(terminat), 0);
      chk("rst_eroare", int'(eroare), 0);
      chk("rst_gol1", int'(gol_1leu), 0);
      chk("rst_stoc5", int'(dut.u_hop5.stoc), 4);
      chk("rst_stoc1", int'(dut.u_hop1.stoc), 8);
      at(4);

      // suma=7, with a refill and a second request injected while busy
      t = cyc;
      push(1, t + 3); push(2, t + 6); push(2, t + 9); push(3, t + 10);
      req(7);
      chk("s7_busy_gata", int'(gata), 0);
      at(t + 5);
      refill();
      at(t + 7);
      cerere_rest = 1'b1;
      suma_rest   = 4'd15;
      @(negedge clk);
      cerere_rest = 1'b0;
      at(t + 10);
      chk("s7_gata_before_idle", int'(gata), 0);
      at(t + 11);
      chk("s7_gata", int'(gata), 1);
      chk("s7_stoc5", int'(dut.u_hop5.stoc), 3);
      chk("s7_stoc1", int'(dut.u_hop1.stoc), 6);

      // suma=0
      t = cyc;
      push(3, t + 2);
      req(0);
      at(t + 3);
      chk("s0_gata", int'(gata), 1);

      refill();
      chk("refill1_stoc5", int'(dut.u_hop5.stoc), 4);
      chk("refill1_stoc1", int'(dut.u_hop1.stoc), 8);

      // four 5-leu requests drain the 5-leu hopper; the second carries a refill that must lose
      for (int i = 0; i < 4; i++) begin
         t = cyc;
         push(1, t + 3); push(3, t + 4);
         reincarca = (i == 1);
         req(5);
         reincarca = 1'b0;
         at(t + 5);
         chk("s5_gata", int'(gata), 1);
      end
      chk("drain_stoc5", int'(dut.u_hop5.stoc), 0);
      chk("drain_stoc1", int'(dut.u_hop1.stoc), 8);

      // suma=9 cannot be paid from 8 one-leu coins
      t = cyc;
      push(4, t + 3);
      req(9);
      at(t + 3);
      chk("err_eroare", int'(eroare), 1);
      chk("err_gata", int'(gata), 1);
      chk("err_stoc5", int'(dut.u_hop5.stoc), 0);
      chk("err_stoc1", int'(dut.u_hop1.stoc), 8);

      // suma=3 clears eroare and pays three 1-leu coins
      t = cyc;
      push(2, t + 2); push(2, t + 5); push(2, t + 8); push(3, t + 9);
      req(3);
      chk("s3_eroare_clr", int'(eroare), 0);
      at(t + 10);
      chk("s3_gata", int'(gata), 1);
      chk("s3_stoc1", int'(dut.u_hop1.stoc), 5);
      chk("s3_gol1", int'(gol_1leu), 0);

      // suma=5 with no 5-leu coins empties the 1-leu hopper exactly
      t = cyc;
      push(2, t + 2); push(2, t + 5); push(2, t + 8); push(2, t + 11); push(2, t + 14);
      push(3, t + 15);
      req(5);
      at(t + 16);
      chk("s5b_gata", int'(gata), 1);
      chk("s5b_stoc1", int'(dut.u_hop1.stoc), 0);
      chk("s5b_gol1", int'(gol_1leu), 1);

      refill();
      chk("refill2_stoc5", int'(dut.u_hop5.stoc), 4);
      chk("refill2_stoc1", int'(dut.u_hop1.stoc), 8);
      chk("refill2_gol1", int'(gol_1leu), 0);

      // reset during the pause after the first coin aborts the payout
      t = cyc;
      push(1, t + 3);
      req(7);
      at(t + 4);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_gata", int'(gata), 1);
      chk("abort_stoc5", int'(dut.u_hop5.stoc), 4);
      chk("abort_stoc1", int'(dut.u_hop1.stoc), 8);
      at(t + 14);
      chk("abort_gata_late", int'(gata), 1);

      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
